// File: rtl/dm_access_pkg.sv
// Shared types and constants for the data-memory access unit.
package dm_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_e;

    localparam int unsigned WORD_SHIFT = 2;

    // Size code 2'b11 has no meaning of its own and behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] raw);
        case (raw)
            2'b00:   norm_size = SZ_BYTE;
            2'b01:   norm_size = SZ_HALF;
            default: norm_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_unit_lane_align.sv
// Combinational lane steering: load extraction/extension and sub-word store merge.
module dm_lane_align
    import dm_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_val,
    output logic [31:0] merge_val
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, extend it for loads and splice new data in for stores.
    always_comb begin
        byte_s    = old_word[{offset, 3'b000} +: 8];
        half_s    = old_word[{offset[1], 4'b0000} +: 16];
        load_val  = old_word;
        merge_val = new_data;
        case (size)
            SZ_BYTE: begin
                load_val  = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
                merge_val = old_word;
                merge_val[{offset, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                load_val  = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
                merge_val = old_word;
                merge_val[{offset[1], 4'b0000} +: 16] = new_data[15:0];
            end
            default: begin
                load_val  = old_word;
                merge_val = new_data;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// CPU-side load/store initiator for a word-addressed data memory.
// Optional alignment/range rejection is built when DM_ACCESS_CHECK_EN is defined.
module dm_access_unit
    import dm_access_pkg::*;
#(
    parameter int DEPTH = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dm_access_unit: DEPTH must be positive");
    end

    state_e      state_r;
    logic        we_r;
    size_e       size_r;
    logic        unsigned_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] merge_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic        mem_read_s;
    logic        mem_write_s;
    logic [31:0] mem_wdata_s;
    logic [31:0] load_val_s;
    logic [31:0] merge_val_s;

    dm_lane_align u_lane_align (
        .size        (size_r),
        .offset      (addr_r[1:0]),
        .is_unsigned (unsigned_r),
        .old_word    (mem_rdata),
        .new_data    (wdata_r),
        .load_val    (load_val_s),
        .merge_val   (merge_val_s)
    );

`ifdef DM_ACCESS_CHECK_EN
    logic  reject_s;
    size_e req_size_n_s;

    // Reject misaligned or out-of-range requests before any memory access starts.
    always_comb begin
        req_size_n_s = norm_size(req_size);
        reject_s     = 1'b0;
        if ((req_addr >> WORD_SHIFT) >= 32'(DEPTH)) begin
            reject_s = 1'b1;
        end else if (req_size_n_s == SZ_HALF && req_addr[0]) begin
            reject_s = 1'b1;
        end else if (req_size_n_s == SZ_WORD && req_addr[1:0] != 2'b00) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end
`endif

    // Strobes follow the state directly so an async reset cancels a pending write at once.
    always_comb begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_wdata_s = 32'h0000_0000;
        case (state_r)
            ACCESS: begin
                mem_read_s = 1'b1;
                if (we_r && size_r == SZ_WORD) begin
                    mem_write_s = 1'b1;
                    mem_wdata_s = wdata_r;
                end else begin
                    mem_write_s = 1'b0;
                    mem_wdata_s = 32'h0000_0000;
                end
            end
            WRITE: begin
                mem_write_s = 1'b1;
                mem_wdata_s = merge_r;
            end
            default: begin
                mem_read_s  = 1'b0;
                mem_write_s = 1'b0;
                mem_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Request FSM with latched request and registered response/merge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            we_r         <= 1'b0;
            size_r       <= SZ_BYTE;
            unsigned_r   <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            merge_r      <= 32'h0000_0000;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r         <= req_we;
                        size_r       <= norm_size(req_size);
                        unsigned_r   <= req_unsigned;
                        addr_r       <= req_addr;
                        wdata_r      <= req_wdata;
                        req_ready_r  <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
`ifdef DM_ACCESS_CHECK_EN
                        if (reject_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else begin
                            state_r    <= ACCESS;
                            resp_err_r <= 1'b0;
                        end
`else
                        state_r    <= ACCESS;
                        resp_err_r <= 1'b0;
`endif
                    end
                end
                ACCESS: begin
                    if (!we_r) begin
                        resp_rdata_r <= load_val_s;
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else if (size_r == SZ_WORD) begin
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        merge_r <= merge_val_s;
                        state_r <= WRITE;
                    end
                end
                WRITE: begin
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_read   = mem_read_s;
    assign mem_write  = mem_write_s;
    assign mem_addr   = addr_r >> WORD_SHIFT;
    assign mem_wdata  = mem_wdata_s;

endmodule
